// File: rtl/core_pixel_rotator_if.sv
// Handshake/bus bundle between the rotate core address generator and its
// DMA / buffer neighbours. Clock and reset stay outside as plain ports.
interface core_pixel_rotator_if #(
  parameter int unsigned TILE = 8,
  parameter int unsigned AW   = 8
);
  localparam int unsigned VCW = $clog2(TILE) + 1;

  logic           I_PR_START;
  logic           I_PR_STOP;
  logic [1:0]     I_PR_DEGREES;
  logic           I_PR_DIRECTION;
  logic           I_PR_MIRROR;
  logic [VCW-1:0] I_PR_VALID_COLS;
  logic           I_PR_RD_VALID;
  logic           I_PR_WR_READY;
  logic           O_PR_RD_READY;
  logic           O_PR_IN_WE;
  logic [AW-1:0]  O_PR_IN_WADDR;
  logic           O_PR_XFER_VALID;
  logic [AW-1:0]  O_PR_SRC_ADDR;
  logic [AW-1:0]  O_PR_DST_ADDR;
  logic           O_PR_PAD;
  logic           O_PR_OUT_RVALID;
  logic [AW-1:0]  O_PR_OUT_RADDR;
  logic           O_PR_BUSY;
  logic           O_PR_DONE;

  modport master (
    output I_PR_START, I_PR_STOP, I_PR_DEGREES, I_PR_DIRECTION, I_PR_MIRROR,
           I_PR_VALID_COLS, I_PR_RD_VALID, I_PR_WR_READY,
    input  O_PR_RD_READY, O_PR_IN_WE, O_PR_IN_WADDR, O_PR_XFER_VALID,
           O_PR_SRC_ADDR, O_PR_DST_ADDR, O_PR_PAD, O_PR_OUT_RVALID,
           O_PR_OUT_RADDR, O_PR_BUSY, O_PR_DONE
  );

  modport slave (
    input  I_PR_START, I_PR_STOP, I_PR_DEGREES, I_PR_DIRECTION, I_PR_MIRROR,
           I_PR_VALID_COLS, I_PR_RD_VALID, I_PR_WR_READY,
    output O_PR_RD_READY, O_PR_IN_WE, O_PR_IN_WADDR, O_PR_XFER_VALID,
           O_PR_SRC_ADDR, O_PR_DST_ADDR, O_PR_PAD, O_PR_OUT_RVALID,
           O_PR_OUT_RADDR, O_PR_BUSY, O_PR_DONE
  );
endinterface

// File: rtl/core_pixel_rotator.sv
// Tile-rotation address generator: load beats, per-pixel src/dst addresses for
// quarter-turn rotation with mirror and right-edge padding, then write beats.
module core_pixel_rotator #(
  parameter int unsigned TILE      = 8,
  parameter int unsigned CH        = 3,
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned AW        = 8
) (
  input logic                I_PR_HCLK,
  input logic                I_PR_HRESET_N,
  core_pixel_rotator_if.slave pr
);
  localparam int unsigned LT    = $clog2(TILE);
  localparam int unsigned VCW   = LT + 1;
  localparam int unsigned PW    = 2 * LT;
  localparam int unsigned NPIX  = TILE * TILE;
  localparam int unsigned BEATS = TILE * TILE * CH / BUS_BYTES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [LT-1:0] TMAX = LT'(TILE - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ROTATE, WRITE, DONE} state_t;

  state_t         state;
  logic [BW-1:0]  beat;
  logic [PW-1:0]  pix;
  logic [1:0]     turns;
  logic           mirror;
  logic [VCW-1:0] vcols;

  always_ff @(posedge I_PR_HCLK or negedge I_PR_HRESET_N) begin
    if (!I_PR_HRESET_N) begin
      state  <= IDLE;
      beat   <= '0;
      pix    <= '0;
      turns  <= '0;
      mirror <= 1'b0;
      vcols  <= '0;
    end else if (pr.I_PR_STOP) begin
      state <= IDLE;
      beat  <= '0;
      pix   <= '0;
    end else begin
      case (state)
        IDLE: if (pr.I_PR_START) begin
          state  <= LOAD;
          beat   <= '0;
          pix    <= '0;
          // counter-clockwise n quarter turns == clockwise (4-n) mod 4
          turns  <= pr.I_PR_DIRECTION ? 2'd0 - pr.I_PR_DEGREES : pr.I_PR_DEGREES;
          mirror <= pr.I_PR_MIRROR;
          vcols  <= pr.I_PR_VALID_COLS;
        end
        LOAD: if (pr.I_PR_RD_VALID) begin
          if (beat == BW'(BEATS - 1)) begin
            beat  <= '0;
            state <= ROTATE;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        ROTATE: begin
          if (pix == PW'(NPIX - 1)) begin
            pix   <= '0;
            state <= WRITE;
          end else begin
            pix <= pix + PW'(1);
          end
        end
        WRITE: if (pr.I_PR_WR_READY) begin
          if (beat == BW'(BEATS - 1)) begin
            beat  <= '0;
            state <= DONE;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [LT-1:0]  row, col, colm, dr, dc;
  logic [VCW-1:0] eff_cols;
  logic [AW-1:0]  dst;
  logic           pad;

  always_comb begin
    row  = pix[PW-1:LT];
    col  = pix[LT-1:0];
    colm = mirror ? TMAX - col : col;
    dr   = row;
    dc   = colm;
    case (turns)
      2'd0: begin dr = row;         dc = colm;        end
      2'd1: begin dr = colm;        dc = TMAX - row;  end
      2'd2: begin dr = TMAX - row;  dc = TMAX - colm; end
      2'd3: begin dr = TMAX - colm; dc = row;         end
      default: ;
    endcase
    dst      = (AW'(dr) * AW'(TILE) + AW'(dc)) * AW'(CH);
    eff_cols = (vcols == '0) ? VCW'(TILE) : vcols;
    pad      = ({1'b0, col} >= eff_cols);
  end

  logic in_load, in_rot, in_wr;
  assign in_load = (state == LOAD);
  assign in_rot  = (state == ROTATE);
  assign in_wr   = (state == WRITE);

  // Outputs are gated by state so that every output reads zero in IDLE/reset.
  assign pr.O_PR_RD_READY   = in_load;
  assign pr.O_PR_IN_WE      = pr.I_PR_RD_VALID & in_load;
  assign pr.O_PR_IN_WADDR   = in_load ? AW'(beat) * AW'(BUS_BYTES) : '0;
  assign pr.O_PR_XFER_VALID = in_rot;
  assign pr.O_PR_SRC_ADDR   = in_rot ? AW'(pix) * AW'(CH) : '0;
  assign pr.O_PR_DST_ADDR   = in_rot ? dst : '0;
  assign pr.O_PR_PAD        = in_rot & pad;
  assign pr.O_PR_OUT_RVALID = in_wr;
  assign pr.O_PR_OUT_RADDR  = in_wr ? AW'(beat) * AW'(BUS_BYTES) : '0;
  assign pr.O_PR_BUSY       = (state != IDLE);
  assign pr.O_PR_DONE       = (state == DONE);
endmodule

// File: tb/tb_core_pixel_rotator.sv
// Scoreboard bench for core_pixel_rotator: a reference model pushes expected
// load/rotate/write transactions, a negedge monitor pops and compares them.
module tb_core_pixel_rotator;
  localparam int TILE = 8, CH = 3, BUS_BYTES = 4, AW = 8;
  localparam int NPIX = TILE * TILE;
  localparam int BEATS = NPIX * CH / BUS_BYTES;

  typedef struct {
    int src;
    int dst;
    int pad;
  } rot_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_pixel_rotator_if #(.TILE(TILE), .AW(AW)) pr ();

  core_pixel_rotator #(.TILE(TILE), .CH(CH), .BUS_BYTES(BUS_BYTES), .AW(AW)) dut (
    .I_PR_HCLK    (clk),
    .I_PR_HRESET_N(rst_n),
    .pr           (pr)
  );

  int checks = 0;
  int errors = 0;
  int load_q[$];
  int wr_q[$];
  rot_t rot_q[$];
  int done_cnt = 0;
  int rot_cycles = 0;
  bit exp_done = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: mirror, then apply k clockwise quarter turns one at a time.
  task automatic push_tile(input int deg, input int dir, input int mir, input int vc);
    int k, eff, r, c, rr, cc, t;
    rot_t e;
    k = dir ? (4 - deg) % 4 : deg;
    eff = (vc == 0) ? TILE : vc;
    for (int i = 0; i < BEATS; i++) begin
      load_q.push_back(i * BUS_BYTES);
      wr_q.push_back(i * BUS_BYTES);
    end
    for (int p = 0; p < NPIX; p++) begin
      r = p / TILE;
      c = p % TILE;
      rr = r;
      cc = mir ? TILE - 1 - c : c;
      for (int q = 0; q < k; q++) begin
        t = rr;
        rr = cc;
        cc = TILE - 1 - t;
      end
      e.src = p * CH;
      e.dst = (rr * TILE + cc) * CH;
      e.pad = (c >= eff) ? 1 : 0;
      rot_q.push_back(e);
    end
  endtask

  task automatic clear_sb();
    load_q.delete();
    wr_q.delete();
    rot_q.delete();
    exp_done = 1'b0;
    rot_cycles = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pr.O_PR_IN_WE) begin
        if (load_q.size() == 0) chk("load_unexpected", 1, 0);
        else chk("in_waddr", int'(pr.O_PR_IN_WADDR), load_q.pop_front());
      end
      if (pr.O_PR_XFER_VALID) begin
        rot_cycles++;
        if (rot_q.size() == 0) chk("rot_unexpected", 1, 0);
        else begin
          rot_t e;
          e = rot_q.pop_front();
          chk("src_addr", int'(pr.O_PR_SRC_ADDR), e.src);
          chk("dst_addr", int'(pr.O_PR_DST_ADDR), e.dst);
          chk("pad", int'(pr.O_PR_PAD), e.pad);
        end
      end
      if (pr.O_PR_DONE || exp_done) chk("done_pulse", int'(pr.O_PR_DONE), int'(exp_done));
      exp_done = 1'b0;
      if (pr.O_PR_DONE) begin
        chk("busy_in_done", int'(pr.O_PR_BUSY), 1);
        chk("rotate_cycles", rot_cycles, NPIX);
        rot_cycles = 0;
        done_cnt++;
      end
      if (pr.O_PR_OUT_RVALID && pr.I_PR_WR_READY) begin
        if (wr_q.size() == 0) chk("write_unexpected", 1, 0);
        else begin
          chk("out_raddr", int'(pr.O_PR_OUT_RADDR), wr_q.pop_front());
          if (wr_q.size() == 0) exp_done = 1'b1;
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_rd_ready"}, int'(pr.O_PR_RD_READY), 0);
    chk({tag, "_in_we"}, int'(pr.O_PR_IN_WE), 0);
    chk({tag, "_in_waddr"}, int'(pr.O_PR_IN_WADDR), 0);
    chk({tag, "_xfer_valid"}, int'(pr.O_PR_XFER_VALID), 0);
    chk({tag, "_src"}, int'(pr.O_PR_SRC_ADDR), 0);
    chk({tag, "_dst"}, int'(pr.O_PR_DST_ADDR), 0);
    chk({tag, "_pad"}, int'(pr.O_PR_PAD), 0);
    chk({tag, "_out_rvalid"}, int'(pr.O_PR_OUT_RVALID), 0);
    chk({tag, "_out_raddr"}, int'(pr.O_PR_OUT_RADDR), 0);
    chk({tag, "_busy"}, int'(pr.O_PR_BUSY), 0);
    chk({tag, "_done"}, int'(pr.O_PR_DONE), 0);
  endtask

  task automatic start_tile(input int deg, input int dir, input int mir, input int vc);
    push_tile(deg, dir, mir, vc);
    @(posedge clk); #1;
    pr.I_PR_DEGREES = 2'(deg);
    pr.I_PR_DIRECTION = dir[0];
    pr.I_PR_MIRROR = mir[0];
    pr.I_PR_VALID_COLS = 4'(vc);
    pr.I_PR_START = 1'b1;
    @(posedge clk); #1;
    pr.I_PR_START = 1'b0;
    chk("start_busy", int'(pr.O_PR_BUSY), 1);
    chk("start_rd_ready", int'(pr.O_PR_RD_READY), 1);
  endtask

  task automatic run_tile(input int deg, input int dir, input int mir, input int vc,
                          input int rdp, input int wrp);
    int d0, n;
    d0 = done_cnt;
    start_tile(deg, dir, mir, vc);
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      pr.I_PR_RD_VALID = ($urandom_range(0, 99) < rdp);
      pr.I_PR_WR_READY = ($urandom_range(0, 99) < wrp);
      // mode inputs and stray STARTs while busy must be ignored
      pr.I_PR_DEGREES = 2'($urandom);
      pr.I_PR_DIRECTION = 1'($urandom);
      pr.I_PR_MIRROR = 1'($urandom);
      pr.I_PR_VALID_COLS = 4'($urandom_range(0, TILE));
      pr.I_PR_START = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
      n++;
    end
    pr.I_PR_START = 1'b0;
    pr.I_PR_RD_VALID = 1'b0;
    pr.I_PR_WR_READY = 1'b0;
    chk("tile_done_seen", done_cnt - d0, 1);
    chk("load_left", load_q.size(), 0);
    chk("rot_left", rot_q.size(), 0);
    chk("write_left", wr_q.size(), 0);
    chk("idle_after_done", int'(pr.O_PR_BUSY), 0);
    clear_sb();
  endtask

  initial begin
    int n;
    pr.I_PR_START = 1'b0;
    pr.I_PR_STOP = 1'b0;
    pr.I_PR_DEGREES = 2'd0;
    pr.I_PR_DIRECTION = 1'b0;
    pr.I_PR_MIRROR = 1'b0;
    pr.I_PR_VALID_COLS = '0;
    pr.I_PR_RD_VALID = 1'b0;
    pr.I_PR_WR_READY = 1'b0;
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed modes, full-rate and throttled handshakes.
    run_tile(1, 0, 0, 0, 100, 100);
    run_tile(2, 0, 1, 0, 100, 50);
    run_tile(2, 0, 0, 0, 70, 100);
    run_tile(1, 1, 0, 0, 100, 40);
    run_tile(3, 1, 0, 0, 60, 60);
    run_tile(0, 0, 0, 5, 100, 100);
    run_tile(3, 0, 1, 1, 50, 80);
    run_tile(0, 1, 1, 8, 90, 30);

    // Async reset in the middle of ROTATE.
    start_tile(1, 0, 0, 0);
    pr.I_PR_RD_VALID = 1'b1;
    n = 0;
    while (!pr.O_PR_XFER_VALID && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_rotate", int'(pr.O_PR_XFER_VALID), 1);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midrot_reset");
    clear_sb();
    pr.I_PR_RD_VALID = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Abort after 10 load beats; next tile must restart at address 0.
    start_tile(2, 1, 0, 0);
    pr.I_PR_RD_VALID = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    pr.I_PR_RD_VALID = 1'b0;
    pr.I_PR_STOP = 1'b1;
    chk("stop_beats_left", load_q.size(), BEATS - 10);
    @(posedge clk); #1;
    pr.I_PR_STOP = 1'b0;
    chk("stop_rd_ready", int'(pr.O_PR_RD_READY), 0);
    chk("stop_busy", int'(pr.O_PR_BUSY), 0);
    clear_sb();
    run_tile(1, 0, 1, 0, 100, 100);

    // Random modes and handshake rates.
    for (int t = 0; t < 6; t++)
      run_tile($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, TILE), $urandom_range(30, 100), $urandom_range(30, 100));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
